// File: rtl/linear_sequencer.sv
// Frame controller for one linear_layer: clears the accumulators, streams one input
// vector from a synchronous-read buffer, then waits for the layer result to capture it.
module linear_sequencer #(
    parameter int  DATA_WIDTH   = 24,
    parameter int  INPUT_LENGTH = 784,
    parameter int  TIMEOUT      = 16,
    localparam int AW           = (INPUT_LENGTH > 1) ? $clog2(INPUT_LENGTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  mem_rd_en,
    output logic [AW-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  layer_rst,
    output logic                  layer_valid,
    output logic [DATA_WIDTH-1:0] layer_din,
    input  logic                  layer_o_valid,
    output logic                  capture,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int            TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int            STAGES    = 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(INPUT_LENGTH - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STREAM, S_WAIT} state_t;

    state_t                state;
    logic [STAGES:0]       vld_pipe;  // [0] = read strobe, [STAGES] = word valid at layer
    logic [TW-1:0]         tcnt;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  rst_q;
    logic                  err_q;
    logic                  in_wait;
    logic                  hit_ok;
    logic                  hit_to;
    logic                  kill;

    // abort outranks both a result and a timeout in the same cycle
    assign in_wait = (state == S_WAIT) && !abort;
    assign hit_ok  = in_wait && layer_o_valid;
    assign hit_to  = in_wait && !layer_o_valid && (tcnt == LAST_TICK);
    assign kill    = (state != S_IDLE) && abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            vld_pipe <= '0;
            mem_addr <= '0;
            tcnt     <= '0;
            din_q    <= '0;
            rst_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            rst_q              <= 1'b0;
            if (vld_pipe[STAGES])
                din_q <= mem_rdata;
            if (kill) begin
                state    <= S_IDLE;
                vld_pipe <= '0;
                rst_q    <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state    <= S_CLEAR;
                            rst_q    <= 1'b1;
                            err_q    <= 1'b0;
                            mem_addr <= '0;
                        end
                    end
                    S_CLEAR: begin
                        state       <= S_STREAM;
                        vld_pipe[0] <= 1'b1;
                        mem_addr    <= '0;
                    end
                    S_STREAM: begin
                        if (mem_addr == LAST_ADDR) begin
                            state       <= S_WAIT;
                            vld_pipe[0] <= 1'b0;
                            tcnt        <= '0;
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (hit_ok) begin
                            state <= S_IDLE;
                        end else if (hit_to) begin
                            state <= S_IDLE;
                            err_q <= 1'b1;
                            rst_q <= 1'b1;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // The buffer's own output register is the data stage; din_q only holds the
    // last delivered word while no word is valid.
    assign mem_rd_en   = vld_pipe[0];
    assign layer_valid = vld_pipe[STAGES];
    assign layer_din   = layer_valid ? mem_rdata : din_q;
    assign layer_rst   = rst_q;
    assign busy        = (state != S_IDLE);
    assign capture     = hit_ok;
    assign done        = hit_ok || hit_to;
    assign err         = err_q || hit_to;

endmodule
